// File: rtl/shift_pkg.sv
// Shared types for the shift operand loader: FSM states, shift-function codes, default width.
package shift_pkg;

  localparam int unsigned SHIFT_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    WAIT_CMD = 2'd1,
    PRESENT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SHL  = 2'd0,
    SHR  = 2'd1,
    PASS = 2'd2,
    ASR  = 2'd3
  } shift_fn_e;

endpackage

// File: rtl/shift_operand_loader_nibble_collector.sv
// Operand shift register and nibble counter; flags the edge that completes an operand.
module nibble_collector
  import shift_pkg::*;
#(
  parameter int unsigned N = SHIFT_N_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [3:0]        nib_data,
  output logic [2**N-1:0]   operand,
  output logic [N-2:0]      cnt,
  output logic              done
);

  localparam int unsigned W      = 2**N;
  localparam int unsigned LAST_I = W / 4 - 1;
  localparam logic [N-2:0] LAST  = LAST_I[N-2:0];

  logic [W-1:0] operand_q, operand_d;
  logic [N-2:0] cnt_q, cnt_d;

  always_comb begin
    operand_d = operand_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    if (clear) begin
      operand_d = '0;
      cnt_d     = '0;
    end else if (shift_en) begin
      // First nibble ends up at the MSB end once all W/4 have been shifted in.
      operand_d = {operand_q[W-5:0], nib_data};
      if (cnt_q == LAST) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand_q <= '0;
      cnt_q     <= '0;
    end else begin
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
    end
  end

  assign operand = operand_q;
  assign cnt     = cnt_q;

endmodule

// File: rtl/shift_operand_loader.sv
// Collects a 2**N-bit operand as nibbles, pairs it with a shift command and presents the bundle.
// Define SHIFT_LOADER_REUSE_EN to keep the operand after output acceptance for further commands.
module shift_operand_loader
  import shift_pkg::*;
#(
  parameter int unsigned N = SHIFT_N_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              nib_valid,
  input  logic [3:0]        nib_data,
  output logic              nib_ready,
  input  logic              cmd_valid,
  input  logic [N-1:0]      cmd_sh,
  input  logic [1:0]        cmd_f,
  output logic              cmd_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_a,
  output logic [N-1:0]      out_sh,
  output logic [1:0]        out_f,
  output logic [N-2:0]      nib_cnt
);

  localparam int unsigned W = 2**N;

  state_e       state_q, state_d;
  logic [W-1:0] out_a_q, out_a_d;
  logic [N-1:0] out_sh_q, out_sh_d;
  logic [1:0]   out_f_q, out_f_d;

  logic         nib_fire, cmd_fire, out_fire;
  logic         col_clear, col_done;
  logic [W-1:0] col_operand;

  assign nib_ready = (state_q == LOAD);
  assign cmd_ready = (state_q == WAIT_CMD);
  assign out_valid = (state_q == PRESENT);

  // Abort wins over every handshake in the same cycle.
  assign nib_fire = nib_valid & nib_ready & ~abort;
  assign cmd_fire = cmd_valid & cmd_ready & ~abort;
  assign out_fire = out_valid & out_ready & ~abort;

`ifdef SHIFT_LOADER_REUSE_EN
  assign col_clear = abort;
`else
  assign col_clear = abort | out_fire;
`endif

  nibble_collector #(
    .N (N)
  ) u_collector (
    .clk      (clk),
    .reset    (reset),
    .clear    (col_clear),
    .shift_en (nib_fire),
    .nib_data (nib_data),
    .operand  (col_operand),
    .cnt      (nib_cnt),
    .done     (col_done)
  );

  always_comb begin
    state_d  = state_q;
    out_a_d  = out_a_q;
    out_sh_d = out_sh_q;
    out_f_d  = out_f_q;
    unique case (state_q)
      LOAD: begin
        if (col_done) state_d = WAIT_CMD;
      end
      WAIT_CMD: begin
        if (cmd_fire) begin
          state_d  = PRESENT;
          out_a_d  = col_operand;
          out_sh_d = cmd_sh;
          out_f_d  = cmd_f;
        end
      end
      PRESENT: begin
        if (out_fire) begin
`ifdef SHIFT_LOADER_REUSE_EN
          state_d = WAIT_CMD;
`else
          state_d = LOAD;
          out_a_d = '0;
`endif
        end
      end
      default: state_d = LOAD;
    endcase
    if (abort) begin
      state_d = LOAD;
      out_a_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      out_a_q  <= '0;
      out_sh_q <= '0;
      out_f_q  <= PASS;
    end else begin
      state_q  <= state_d;
      out_a_q  <= out_a_d;
      out_sh_q <= out_sh_d;
      out_f_q  <= out_f_d;
    end
  end

  assign out_a  = out_a_q;
  assign out_sh = out_sh_q;
  assign out_f  = out_f_q;

endmodule

// File: tb/tb_shift_operand_loader.sv
// Directed and randomized checks of shift_operand_loader against a transaction-level model.
module tb_shift_operand_loader;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset, abort;
  logic           nib_valid, nib_ready;
  logic [3:0]     nib_data;
  logic           cmd_valid, cmd_ready;
  logic [N-1:0]   cmd_sh, out_sh;
  logic [1:0]     cmd_f, out_f;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_a;
  logic [N-2:0]   nib_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: operand value, nibbles held, operand complete, bundle being presented.
  int m_a, m_nibs, m_sh, m_f;
  bit m_full, m_pres;
  int dut_nib_acc;

`ifdef SHIFT_LOADER_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  shift_operand_loader #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .nib_valid (nib_valid),
    .nib_data  (nib_data),
    .nib_ready (nib_ready),
    .cmd_valid (cmd_valid),
    .cmd_sh    (cmd_sh),
    .cmd_f     (cmd_f),
    .cmd_ready (cmd_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_sh    (out_sh),
    .out_f     (out_f),
    .nib_cnt   (nib_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_nibs = 0; m_sh = 0; m_f = 2;
    m_full = 1'b0; m_pres = 1'b0;
  endtask

  task automatic model_step();
    if (abort) begin
      m_a = 0; m_nibs = 0; m_full = 1'b0; m_pres = 1'b0;
    end else if (m_pres) begin
      if (out_ready) begin
        m_pres = 1'b0;
        if (!REUSE) begin
          m_full = 1'b0;
          m_a    = 0;
        end
      end
    end else if (m_full) begin
      if (cmd_valid) begin
        m_sh = int'(cmd_sh); m_f = int'(cmd_f); m_pres = 1'b1;
      end
    end else if (nib_valid) begin
      m_a = (m_a * 16 + int'(nib_data)) % 65536;
      m_nibs++;
      if (m_nibs == W / 4) begin
        m_nibs = 0;
        m_full = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("nib_ready", 32'(nib_ready), 32'(!m_full));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_full && !m_pres));
    chk("out_valid", 32'(out_valid), 32'(m_pres));
    chk("nib_cnt",   32'(nib_cnt),   32'(m_nibs));
    if (m_pres) begin
      chk("out_a",  32'(out_a),  32'(m_a));
      chk("out_sh", 32'(out_sh), 32'(m_sh));
      chk("out_f",  32'(out_f),  32'(m_f));
    end
  endtask

  // One clock: compare, advance the model with the driven inputs, step past the edge.
  task automatic cycle();
    check_outputs();
    if (nib_valid && nib_ready) dut_nib_acc++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    abort = 0; nib_valid = 0; cmd_valid = 0; out_ready = 0;
    nib_data = '0; cmd_sh = '0; cmd_f = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_nib_cnt",   32'(nib_cnt),   32'd0);
    chk("rst_out_a",     32'(out_a),     32'd0);
    chk("rst_out_sh",    32'(out_sh),    32'd0);
    chk("rst_out_f",     32'(out_f),     32'd2);
    reset = 1'b0;
    #1;
    chk("rst_nib_ready", 32'(nib_ready), 32'd1);
  endtask

  task automatic load_word(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      nib_valid = 1'b1;
      nib_data  = w[15 - 4*i -: 4];
      cycle();
    end
    nib_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [N-1:0] sh, input logic [1:0] f);
    cmd_valid = 1'b1; cmd_sh = sh; cmd_f = f;
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] held_a;
    idle();
    reset = 1'b0;
    dut_nib_acc = 0;
    model_reset();
    #2;
    do_reset();

    // Basic transfer: 1,0,B,6 then sh=3/f=SHL, accepted immediately.
    load_word(16'h10B6);
    send_cmd(4'd3, 2'd0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_a",     32'(out_a),     32'h10B6);
    chk("t1_sh",    32'(out_sh),    32'd3);
    chk("t1_f",     32'(out_f),     32'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t1_valid_one_cycle", 32'(out_valid), 32'd0);

`ifdef SHIFT_LOADER_REUSE_EN
    chk("reuse_cmd_ready", 32'(cmd_ready), 32'd1);
    send_cmd(4'd1, 2'd1);
    chk("reuse_a",  32'(out_a),  32'h10B6);
    chk("reuse_sh", 32'(out_sh), 32'd1);
    chk("reuse_f",  32'(out_f),  32'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
`else
    cmd_valid = 1'b1; cmd_sh = 4'd1; cmd_f = 2'd1;
    for (int i = 0; i < 3; i++) begin
      chk("noreuse_cmd_blocked", 32'(cmd_ready), 32'd0);
      cycle();
    end
    load_word(16'hA5C3);
    cmd_valid = 1'b0;
    chk("noreuse_cmd_ready", 32'(cmd_ready), 32'd1);
    send_cmd(4'd1, 2'd1);
    chk("noreuse_a", 32'(out_a), 32'hA5C3);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
`endif

    // Backpressure: bundle holds for 5 cycles, accepted on the 6th.
    w = 16'($urandom);
    load_word(w);
    send_cmd(4'($urandom), 2'd3);
    held_a = out_a;
    chk("bp_a_start", 32'(held_a), 32'(w));
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_a", 32'(out_a), 32'(w));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("bp_accepted", 32'(out_valid), 32'd0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;

    // Abort coincident with the third nibble handshake.
    nib_valid = 1'b1;
    nib_data = 4'h3; cycle();
    nib_data = 4'h7; cycle();
    nib_data = 4'h9; abort = 1'b1; cycle();
    abort = 1'b0; nib_valid = 1'b0;
    chk("abort_cnt",   32'(nib_cnt),   32'd0);
    chk("abort_load",  32'(nib_ready), 32'd1);
    load_word(16'hFFFF);
    send_cmd(4'd2, 2'd2);
    chk("abort_ffff", 32'(out_a), 32'hFFFF);

    // Asynchronous reset between clock edges while presenting.
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_f",     32'(out_f),     32'd2);
    chk("async_cnt",   32'(nib_cnt),   32'd0);
    chk("async_a",     32'(out_a),     32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;

    // Both producers valid continuously: exactly W/4 nibbles before cmd_ready.
    dut_nib_acc = 0;
    nib_valid = 1'b1; cmd_valid = 1'b1; cmd_sh = 4'd5; cmd_f = 2'd1;
    for (int i = 0; i < 4; i++) begin
      chk("cont_no_cmd_yet", 32'(cmd_ready), 32'd0);
      nib_data = 4'($urandom);
      cycle();
    end
    chk("cont_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      nib_data = 4'($urandom);
      cycle();
    end
    chk("cont_nibs", 32'(dut_nib_acc), 32'd4);
    idle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      abort     = ($urandom_range(0, 24) == 0);
      nib_valid = $urandom_range(0, 1) == 1;
      nib_data  = 4'($urandom);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_sh    = 4'($urandom);
      cmd_f     = 2'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      cycle();
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_operand_loader.md
SHIFT_OPERAND_LOADER -- requirements
Module: shift_operand_loader

Interface
REQ-001 The block SHALL have parameter N, default 4: shift-amount width; datapath width is 2**N.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port abort, input, 1 bit: synchronous discard of the current operand and command.
REQ-005 The block SHALL have ports nib_valid (input, 1), nib_data (input, 4) and nib_ready (output, 1): operand nibble handshake.
REQ-006 The block SHALL have ports cmd_valid (input, 1), cmd_sh (input, N), cmd_f (input, 2) and cmd_ready (output, 1): shift command handshake.
REQ-007 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_a (output, 2**N), out_sh (output, N) and out_f (output, 2): operand bundle to the downstream shifter.
REQ-008 The block SHALL have port nib_cnt (output, N-1): number of nibbles accepted so far.

Function
REQ-009 A transfer SHALL occur on any channel only in a cycle where valid and ready are both high.
REQ-010 The FSM SHALL have exactly three states: LOAD, WAIT_CMD and PRESENT.
REQ-011 In LOAD, nib_ready=1, cmd_ready=0 and out_valid=0.
REQ-012 Each accepted nibble SHALL be shifted into the operand LSB end (A <= {A[2**N-5:0], nib_data}), so the first nibble lands at the MSB end and the last at the LSB end.
REQ-013 The nibble counter SHALL increment per accepted nibble, and on acceptance of nibble number 2**N/4 it SHALL wrap to 0 with the state moving to WAIT_CMD in the same edge.
REQ-014 In WAIT_CMD, nib_ready=0 and cmd_ready=1; on command acceptance, cmd_sh and cmd_f SHALL be registered and the state SHALL move to PRESENT.
REQ-015 In PRESENT, out_valid=1 and out_a, out_sh and out_f SHALL be driven directly from registers (zero combinational path from inputs); these outputs SHALL hold stable while out_ready=0.
REQ-016 On output acceptance, the next state SHALL be as given by REQ-022/REQ-023.
REQ-017 Latency: the first out_valid SHALL occur one cycle after command acceptance, and no channel SHALL accept more than one item per cycle.
REQ-018 cmd_f SHALL pass through unmodified; encodings 0=SHL, 1=SHR, 2=PASS, 3=ASR, all legal.
REQ-019 abort=1 SHALL force LOAD, clear the nibble counter and operand, and deassert out_valid at the next edge; abort SHALL take precedence over any simultaneous handshake, which SHALL then be treated as not occurred.
REQ-020 Handshake inputs arriving in a state where the corresponding ready is 0 SHALL be ignored.

Reset
REQ-021 reset SHALL asynchronously force: state=LOAD, nib_cnt=0, out_a=0, out_sh=0, out_f=2 (PASS), out_valid=0, cmd_ready=0, and nib_ready=1 after release; reset asserted mid-transfer SHALL discard all partial data.

Configuration
REQ-022 With SHIFT_LOADER_REUSE_EN defined, output acceptance SHALL return the FSM to WAIT_CMD with out_a retained, so further commands reuse the same operand.
REQ-023 Without SHIFT_LOADER_REUSE_EN, output acceptance SHALL return the FSM to LOAD with the operand cleared to 0.

Structure
REQ-024 Package shift_pkg SHALL hold the state enum type, the shift-function enum (SHL, SHR, PASS, ASR) and the default N.
REQ-025 One sub-module, nibble_collector, SHALL contain the operand shift register and nibble counter and report completion; the FSM and output registers SHALL reside in the top module.

Verification
REQ-026 The bench SHALL cover: nibbles 1,0,B,6, then cmd sh=3/f=0, with out_ready=1 -> out_a=16'h10B6, out_sh=3, out_f=0, out_valid high for exactly 1 cycle.
REQ-027 The bench SHALL cover: out_ready held 0 for 5 cycles in PRESENT -> out_a, out_sh and out_f unchanged and out_valid=1 throughout; accepted on the 6th cycle.
REQ-028 The bench SHALL cover: abort asserted together with the 3rd nibble handshake -> nib_cnt=0, state LOAD, and the next 4 nibbles F,F,F,F yield out_a=16'hFFFF.
REQ-029 The bench SHALL cover: reset pulsed mid-cycle in PRESENT -> out_valid=0 immediately, out_f=2, nib_cnt=0.
REQ-030 The bench SHALL cover REUSE_EN: after accepting 16'h10B6 output, a second cmd sh=1/f=1 -> out_a=16'h10B6 with no nibbles loaded; without the macro -> cmd_ready=0 until 4 new nibbles are loaded.
REQ-031 The bench SHALL cover: nib_valid=1 and cmd_valid=1 held continuously -> exactly 4 nibbles accepted before cmd_ready rises, and no nibble accepted in WAIT_CMD or PRESENT.
